// File: rtl/float_to_fixed_serial.sv
// rtl/float_to_fixed_serial.sv - half-precision float to signed fixed point, one shift bit per cycle
module float_to_fixed_serial #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 8,
  localparam int W = INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  float_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] fixed_out,
  output logic         overflow,
  output logic         zero,
  output logic         nan,
  output logic         precisionLost
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

  localparam logic [W-1:0] MAX_MAG = {1'b0, {(W-1){1'b1}}};

  state_t state, next_state;

  logic [W-1:0] mag;
  logic [7:0]   cnt;
  logic         left;
  logic         sign;

  logic [4:0]        f_exp;
  logic [9:0]        f_frac;
  logic [4:0]        e;
  logic signed [9:0] k;
  logic signed [9:0] neg_k;
  logic [W-1:0]      acc_mag;
  logic [7:0]        acc_cnt;
  logic              acc_left;
  logic              acc_ovf;
  logic              acc_nan;
  logic [W-1:0]      res_mag;

  assign f_exp   = float_in[14:10];
  assign f_frac  = float_in[9:0];
  assign res_mag = overflow ? MAX_MAG : mag;

  // Decode of the incoming float into a starting magnitude and shift plan
  always_comb begin
    acc_mag  = '0;
    acc_cnt  = '0;
    acc_left = 1'b0;
    acc_ovf  = 1'b0;
    acc_nan  = 1'b0;
    e        = (f_exp == 5'd0) ? 5'd1 : f_exp;
    k        = $signed({5'b0, e}) + $signed(10'(FRAC_BITS - 25));
    neg_k    = -k;
    if (f_exp == 5'd31) begin
      if (f_frac != 10'd0) begin
        acc_nan = 1'b1;
      end else begin
        acc_ovf = 1'b1;
        acc_mag = MAX_MAG;
      end
    end else if (!(f_exp == 5'd0 && f_frac == 10'd0)) begin
      acc_mag = W'({f_exp != 5'd0, f_frac});
      if (k > 10'sd0) begin
        acc_left = 1'b1;
        acc_cnt  = k[7:0];
      end else if (k < 10'sd0) begin
        // every mantissa bit is gone after 12 right shifts
        acc_cnt = (neg_k > 10'sd12) ? 8'd12 : neg_k[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (cnt == 8'd0) next_state = FINISH;
      FINISH:  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag           <= '0;
      cnt           <= '0;
      left          <= 1'b0;
      sign          <= 1'b0;
      fixed_out     <= '0;
      overflow      <= 1'b0;
      zero          <= 1'b0;
      nan           <= 1'b0;
      precisionLost <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag           <= acc_mag;
          cnt           <= acc_cnt;
          left          <= acc_left;
          sign          <= float_in[15];
          fixed_out     <= '0;
          overflow      <= acc_ovf;
          nan           <= acc_nan;
          zero          <= 1'b0;
          precisionLost <= 1'b0;
        end
        SHIFT: if (cnt != 8'd0) begin
          if (left) begin
            if (mag[W-2]) overflow <= 1'b1;
            mag <= mag << 1;
          end else begin
            if (mag[0]) precisionLost <= 1'b1;
            mag <= mag >> 1;
          end
          cnt <= cnt - 8'd1;
        end
        FINISH: begin
          // saturation keeps the result symmetric, so -2^(W-1) never appears
          fixed_out <= sign ? (~res_mag + 1'b1) : res_mag;
          zero      <= (res_mag == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_serial.sv
// tb/tb_float_to_fixed_serial.sv - checks the converter against an arithmetic reference model
module tb_float_to_fixed_serial;

  localparam int INT_BITS  = 16;
  localparam int FRAC_BITS = 8;
  localparam int W = INT_BITS + FRAC_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  float_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fixed_out;
  logic         overflow;
  logic         zero;
  logic         nan;
  logic         precisionLost;

  int tests = 0;
  int fails = 0;

  float_to_fixed_serial #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .float_in(float_in),
    .out_valid(out_valid), .out_ready(out_ready), .fixed_out(fixed_out),
    .overflow(overflow), .zero(zero), .nan(nan), .precisionLost(precisionLost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value-level model: scale the real value by 2^FRAC_BITS and truncate toward zero
  task automatic model(input logic [15:0] f, output logic [W-1:0] fx,
                       output logic ov, output logic z, output logic nn,
                       output logic pl, output int n);
    longint m, full, maxm, mg;
    int ex, fr, k;
    maxm = (longint'(1) << (W-1)) - 1;
    ex = int'(f[14:10]);
    fr = int'(f[9:0]);
    ov = 0; nn = 0; pl = 0; n = 0; mg = 0;
    if (ex == 31) begin
      if (fr != 0) nn = 1;
      else begin ov = 1; mg = maxm; end
    end else if (!(ex == 0 && fr == 0)) begin
      m = (ex == 0) ? longint'(fr) : longint'(1024 + fr);
      k = ((ex == 0) ? 1 : ex) - 25 + FRAC_BITS;
      if (k >= 0) begin
        n = k;
        full = m << k;
        if (full > maxm) begin ov = 1; mg = maxm; end
        else mg = full;
      end else begin
        n = (-k > 12) ? 12 : -k;
        mg = m >> n;
        pl = (m % (longint'(1) << n)) != 0;
      end
    end
    z = (mg == 0);
    fx = f[15] ? W'(-mg) : W'(mg);
  endtask

  task automatic conv(input logic [15:0] f, input int stall);
    logic [W-1:0] e_fx;
    logic e_ov, e_z, e_nn, e_pl;
    int n, cyc;
    model(f, e_fx, e_ov, e_z, e_nn, e_pl, n);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    float_in = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    float_in = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency_%h", f), 32'(cyc), 32'(n + 2));
    chk($sformatf("fixed_%h", f), 32'(fixed_out), 32'(e_fx));
    chk($sformatf("overflow_%h", f), 32'(overflow), 32'(e_ov));
    chk($sformatf("zero_%h", f), 32'(zero), 32'(e_z));
    chk($sformatf("nan_%h", f), 32'(nan), 32'(e_nn));
    chk($sformatf("plost_%h", f), 32'(precisionLost), 32'(e_pl));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      float_in = 16'($urandom);
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_fixed", 32'(fixed_out), 32'(e_fx));
      chk("stall_flags", 32'({overflow, zero, nan, precisionLost}), 32'({e_ov, e_z, e_nn, e_pl}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] dir_in  [10] = '{16'h3C00, 16'hC500, 16'h3555, 16'h0001, 16'h7BFF,
                                16'hFBFF, 16'h7C00, 16'h7E00, 16'h0000, 16'h8000};
  logic [23:0] dir_exp [10] = '{24'h000100, 24'hFFFB00, 24'h000055, 24'h000000, 24'h7FFFFF,
                                24'h800001, 24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    float_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fixed", 32'(fixed_out), 32'd0);
    chk("rst_flags", 32'({overflow, zero, nan, precisionLost}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      conv(dir_in[i], 0);
      chk($sformatf("table_%h", dir_in[i]), 32'(fixed_out), 32'(dir_exp[i]));
    end

    conv(16'hBC00, 10);

    @(negedge clk);
    in_valid = 1'b1;
    float_in = 16'h7BFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fixed", 32'(fixed_out), 32'd0);
    chk("midrst_flags", 32'({overflow, zero, nan, precisionLost}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    conv(16'h3C00, 0);

    for (int i = 0; i < 40; i++) begin
      conv(16'($urandom), (i % 7 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_to_fixed_serial.md
Name: float_to_fixed_serial

Overview:
- Iterative converter from IEEE-754 half precision (1 sign, 5 exponent, 10 fraction, bias 15) to two's-complement signed fixed point.
- Sits on the output side of float_adder, so float results can be consumed by fixed-point logic.
- Alignment uses a one-bit-per-cycle barrel-free shifter.
- Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
INT_BITS, 16, integer bits of the output, sign bit included
FRAC_BITS, 8, fraction bits of the output; W = INT_BITS+FRAC_BITS, W >= 12 required

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  float_in valid
in_ready  output  1  converter can accept; high only in IDLE
float_in  input  16  {sign, exp[4:0], frac[9:0]}
out_valid  output  1  result and flags valid; held until consumed
out_ready  input  1  consumer accepts result
fixed_out  output  W  two's-complement result, FRAC_BITS fraction bits
overflow  output  1  magnitude saturated (includes infinity)
zero  output  1  fixed_out == 0
nan  output  1  input was NaN
precisionLost  output  1  a nonzero bit was truncated by right shift

Behaviour:
- Reset (asynchronous, any state): state=IDLE; in_ready=1; out_valid=0; fixed_out=0; all flags 0. Reset in the middle of a conversion abandons it and produces no output.
- States: IDLE, SHIFT, FINISH, DONE.
- IDLE, accept on in_valid & in_ready at an edge:
  - Normal input (exp 1..30): mag = {1, frac}, zero-extended to W bits; e = exp.
  - Subnormal input (exp 0): mag = {0, frac}; e = 1.
  - k = e - 25 + FRAC_BITS.
  - Direction: left if k > 0, right if k < 0.
  - cnt = |k|; for right shifts cnt is capped at 12.
  - Latch sign. Clear all flags. Next state SHIFT.
- Special inputs on accept:
  - exp = 31, frac != 0: nan=1, mag=0, cnt=0.
  - exp = 31, frac = 0: overflow=1, mag = 2^(W-1)-1, cnt=0.
  - exp = 0, frac = 0: mag=0, cnt=0.
- SHIFT, per cycle:
  - cnt > 0: shift mag one bit and decrement cnt.
  - Left shift: if mag[W-2]==1 before the shift, set overflow (sticky).
  - Right shift: if mag[0]==1 before the shift, set precisionLost (sticky).
  - cnt == 0: go to FINISH with no shift.
- FINISH, one cycle:
  - If overflow: magnitude = 2^(W-1)-1.
  - fixed_out = sign ? -magnitude : magnitude. -2^(W-1) is never produced.
  - zero = (magnitude == 0). Negative zero yields 0 with zero=1.
  - Next state DONE.
- DONE: out_valid=1; fixed_out and flags stable. On out_ready, go to IDLE at the next edge and drop out_valid. in_ready rises in that same IDLE cycle. There is no accept in the DONE cycle.
- Latency: out_valid rises n+2 cycles after the accept edge, where n = shift count actually performed. Throughput: one conversion per n+4 cycles when out_ready is tied high.
- Truncation is toward zero on magnitude, before negation.
- in_valid and float_in are ignored outside IDLE. float_in may change freely after accept.
- Default width W=24 is used for the test values below.

Test Plan:
- 0x3C00 (1.0) -> k=-2; fixed_out=0x000100; all flags 0; out_valid 4 cycles after accept.
- 0xC500 (-5.0) -> k=0; fixed_out=0xFFFB00; flags 0; out_valid 2 cycles after accept.
- 0x3555 -> fixed_out=0x000055, precisionLost=1; 0x0001 (subnormal) -> fixed_out=0, zero=1, precisionLost=1, 12 shifts.
- Saturation: 0x7BFF -> overflow=1, fixed_out=0x7FFFFF after 13 shifts; 0xFBFF -> 0x800001; 0x7C00 (infinity) -> overflow=1, 0x7FFFFF; 0x7E00 -> nan=1, fixed_out=0.
- Zero inputs: 0x0000 and 0x8000 -> fixed_out=0, zero=1, latency 2.
- Handshake: hold out_ready=0 for 10 cycles -> out_valid, result and flags stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next edge.
- Reset: assert rst mid-SHIFT on 0x7BFF -> immediate IDLE, out_valid=0; the next input converts correctly.
